// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, response and data-memory signals of mem_access_unit
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [DATA_W-1:0] ReqWData;

  logic              RespValid;
  logic [DATA_W-1:0] RespData;
  logic              RespError;

  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqSize, ReqSigned, ReqWData, MemReadData,
    output ReqReady, RespValid, RespData, RespError,
    output MemAddress, MemWriteData, MemRead, MemWrite
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqSize, ReqSigned, ReqWData, MemReadData,
    input  ReqReady, RespValid, RespData, RespError,
    input  MemAddress, MemWriteData, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator with read-modify-write sub-word stores
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic              req_write;
  logic              req_signed;
  logic [1:0]        req_size;
  logic [1:0]        req_off;
  logic [15:0]       req_wdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              resp_error;

  logic              accept;
  logic              req_err;
  logic              req_word_store;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  assign accept = (state == IDLE) && bus.ReqValid;

  always_comb begin
    req_err = 1'b0;
    case (bus.ReqSize)
      SZ_HALF: req_err = bus.ReqAddr[0];
      SZ_WORD: req_err = |bus.ReqAddr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    req_word_store = bus.ReqWrite && (bus.ReqSize == SZ_WORD);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (req_err)             state_nxt = RESP;
          else if (req_word_store) state_nxt = WR;
          else                     state_nxt = RD;
        end
      end
      RD:      state_nxt = RDW;
      RDW:     state_nxt = req_write ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lanes are little-endian: byte k sits at bits [8k+7:8k] of the memory word.
  always_comb begin
    rd_byte = 8'h00;
    case (req_off)
      2'd0:    rd_byte = bus.MemReadData[7:0];
      2'd1:    rd_byte = bus.MemReadData[15:8];
      2'd2:    rd_byte = bus.MemReadData[23:16];
      default: rd_byte = bus.MemReadData[31:24];
    endcase
    rd_half = req_off[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];

    load_val = bus.MemReadData;
    if (req_size == SZ_BYTE)
      load_val = {{24{req_signed & rd_byte[7]}}, rd_byte};
    else if (req_size == SZ_HALF)
      load_val = {{16{req_signed & rd_half[15]}}, rd_half};

    merged = bus.MemReadData;
    if (req_size == SZ_BYTE)
      merged[{req_off, 3'b000} +: 8] = req_wdata[7:0];
    else if (req_size == SZ_HALF)
      merged[{req_off[1], 4'b0000} +: 16] = req_wdata;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_write   <= 1'b0;
      req_signed  <= 1'b0;
      req_size    <= 2'd0;
      req_off     <= 2'd0;
      req_wdata   <= 16'h0000;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
    end else begin
      if (accept) begin
        req_write   <= bus.ReqWrite;
        req_signed  <= bus.ReqSigned;
        req_size    <= bus.ReqSize;
        req_off     <= bus.ReqAddr[1:0];
        req_wdata   <= bus.ReqWData[15:0];
        mem_address <= {2'b00, bus.ReqAddr[ADDR_W-1:2]};
        resp_data   <= '0;
        resp_error  <= req_err;
        if (!req_err && req_word_store)
          mem_wdata <= bus.ReqWData;
      end
      if (state == RDW) begin
        if (req_write) mem_wdata <= merged;
        else           resp_data <= load_val;
      end
      // Keep the error flag low outside the response cycle.
      if (state == RESP)
        resp_error <= 1'b0;
    end
  end

  assign bus.ReqReady     = (state == IDLE);
  assign bus.MemRead      = (state == RD);
  assign bus.MemWrite     = (state == WR);
  assign bus.RespValid    = (state == RESP);
  assign bus.RespData     = resp_data;
  assign bus.RespError    = resp_error;
  assign bus.MemAddress   = mem_address;
  assign bus.MemWriteData = mem_wdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: takes byte-addressed load/store requests from the CPU datapath and drives the word-addressed data memory (Address, WriteData, MemRead, MemWrite, ReadData).
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Implements sub-word stores as read-modify-write, because the memory only writes whole words.
- Single outstanding request; valid/ready on the request side, single-cycle response pulse.

Parameters:
- DATA_W, 32, memory word width; the design is fixed to 4 byte lanes, so only 32 is supported.
- ADDR_W, 32, byte-address width of ReqAddr and width of MemAddress.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  ADDR_W  byte address.
- ReqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- ReqSigned  in  1  load sign-extend enable; ignored on stores.
- ReqWData  in  DATA_W  store data, right-justified.
- RespValid  out  1  one-cycle response pulse.
- RespData  out  DATA_W  load result; 0 for stores and errors.
- RespError  out  1  misaligned or illegal request; qualified by RespValid.
- MemAddress  out  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
- MemWriteData  out  DATA_W  word to write.
- MemRead  out  1  read strobe.
- MemWrite  out  1  write strobe.
- MemReadData  in  DATA_W  memory read port; registered in memory, valid the cycle after the MemRead edge.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE, ReqReady=1.
  - RespValid=0, RespError=0, RespData=0.
  - MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
  - All request latches cleared.
  - Reset mid-operation aborts the operation. No memory strobe is asserted after Rst_n falls.
- All outputs are registered or decoded from state only; no combinational path from Req* to Mem* or Resp*.
- States: IDLE, RD, RDW, WR, RESP.
- IDLE:
  - ReqReady=1.
  - Accept on an edge with ReqValid=1: latch all Req* fields, the byte offset off=ReqAddr[1:0], and MemAddress.
  - Transitions on accept:
    - illegal (ReqSize=11) or misaligned (half with off[0]=1; word with off!=0): go to RESP, RespError=1.
    - word store: go to WR, MemWriteData=ReqWData.
    - anything else (all loads, byte/half stores): go to RD.
  - ReqReady=0 in every state except IDLE; requests offered then are not accepted and must be held by the source.
- RD: MemRead=1 for exactly this cycle; next state RDW.
- RDW: MemReadData is valid.
  - Load:
    - extract the lane little-endian: byte k = bits[8k+7:8k] with k=off; half = bits[16*off[1]+15:16*off[1]].
    - extend: sign-extend if ReqSigned=1, else zero-extend.
    - register the result into RespData; next state RESP.
  - Sub-word store:
    - MemWriteData = MemReadData with the addressed lane(s) replaced by ReqWData[7:0] or ReqWData[15:0]; other bytes unchanged.
    - next state WR.
- WR: MemWrite=1 for exactly this cycle; next state RESP.
- RESP: RespValid=1 for one cycle; next state IDLE.
- Latency, counted in cycles from the accept edge to RespValid high:
  - error: 1.
  - word store: 2.
  - load: 3.
  - sub-word store: 4.
- Request-to-request throughput:
  - the next request may be accepted on the edge that leaves RESP (ReqReady rises in IDLE).
  - one idle cycle minimum between the RESP cycle and the next accept edge.
- Strobes:
  - MemRead and MemWrite are never both 1.
  - MemAddress is stable from the accept edge until leaving RESP.
  - An error request produces no memory strobe.
- RespData=0 and RespError=0 on every non-error store response.

Test Plan:
- Reset, then word store 0x0000_0010 ← 0xDEADBEEF: MemWrite=1 one cycle with MemAddress=4 and MemWriteData=0xDEADBEEF; RespValid 2 cycles after accept; RespError=0.
- Load byte signed addr 0x13 after the above: MemRead one cycle with MemAddress=4; RespData=0xFFFFFFDE 3 cycles after accept. Same load unsigned: RespData=0x000000DE.
- Half store 0x12 ← 0x1234 onto 0xDEADBEEF: read then write; MemWriteData=0x1234BEEF; RespValid 4 cycles after accept. Follow-up word load of 0x10: RespData=0x1234BEEF.
- Misaligned word load 0x11, half load 0x01, and ReqSize=11: RespValid with RespError=1 1 cycle after accept; MemRead and MemWrite stay 0.
- Back-to-back ReqValid held high: ReqReady=0 while busy; second request accepted only in IDLE and served in order.
- Rst_n pulsed low while in RD during a byte store: all outputs return to reset values immediately; no MemWrite occurs; memory word is unchanged on readback.
